bg_trim_filter: RTL and testbench

//  Downstream of the bandgap SAR trim controller. Captures each trim result (coarse/fine IDAC code) on the

---
 rtl/bg_pkg.sv | 17 +
 rtl/bg_code_accum.sv | 59 +++++
 rtl/bg_trim_filter.sv | 137 +++++++++++++
 tb/tb_bg_trim_filter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// Shared types and constants for the bandgap trim filter.
// The trim controller's testbench imports this package too.
`timescale 1ns/1ps
package bg_pkg;

  typedef enum logic [1:0] {IDLE, ACQ, EVAL, LOCKED} bg_filt_state_t;

  localparam int CODE_W = 12;
  localparam logic [CODE_W-1:0] TRIM_CODE_RESET = 12'h800;

  // Filter sample: coarse code with the SAR-resolved fine nibble appended.
  function automatic logic [CODE_W-1:0] pack_code(input logic [7:0] coarse,
                                                   input logic [3:0] fine_hi);
    return {coarse, fine_hi};
  endfunction

endpackage

// File: rtl/bg_code_accum.sv
// Valid edge detection, sample capture and window accumulation for the trim filter.
// The completing window is flagged on window_done; the sum is held until clear.
`timescale 1ns/1ps
module bg_code_accum
  import bg_pkg::*;
#(
  parameter int LOG2N = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              valid,
  input  logic [7:0]        idac_coarse,
  input  logic [3:0]        idac_fine_hi,
  output logic              valid_edge,
  output logic [CODE_W-1:0] avg,
  output logic              window_done
);

  localparam int ACC_W = CODE_W + LOG2N;
  localparam int CNT_W = LOG2N + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << LOG2N) - 1);

  logic              valid_q;
  logic              edge_q;
  logic [CODE_W-1:0] sample_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;

  assign valid_edge = valid & ~valid_q;

  // The sample is registered one stage ahead of the accumulator, so an edge seen
  // during the evaluation cycle lands after the clear and opens the next window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      edge_q   <= 1'b0;
      sample_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      valid_q <= valid;
      edge_q  <= valid_edge;
      if (valid_edge) sample_q <= pack_code(idac_coarse, idac_fine_hi);
      if (clear) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (edge_q) begin
        acc_q <= acc_q + ACC_W'(sample_q);
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign window_done = edge_q && !clear && (cnt_q == LAST_IDX);
  assign avg         = acc_q[ACC_W-1:LOG2N];

endmodule

// File: rtl/bg_trim_filter.sv
// Bandgap trim result filter: windowed averaging, lock detection on agreeing
// averages, held trim code output and a sticky watchdog timeout.
`timescale 1ns/1ps
module bg_trim_filter
  import bg_pkg::*;
#(
  parameter int LOG2N     = 2,
  parameter int TOL       = 2,
  parameter int LOCK_CNT  = 3,
  parameter int TIMEOUT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pwrup,
  input  logic              valid,
  input  logic [7:0]        idacCoarse,
  input  logic [7:0]        idacFine,
  output logic [CODE_W-1:0] trimCode,
  output logic              trimUpdate,
  output logic              locked,
  output logic              timeoutErr
);

  localparam logic [3:0]           LOCK_C   = 4'(LOCK_CNT);
  localparam logic [CODE_W:0]      TOL_C    = (CODE_W + 1)'(TOL);
  localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;

  bg_filt_state_t state_q, state_d;
  logic                 first_q, lk_eval_q, lk_eval_d;
  logic [3:0]           agree_q, agree_d, agree_nxt;
  logic [CODE_W-1:0]    prev_q, avg;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 valid_edge, window_done, is_eval, acc_clear, agree;
  logic signed [CODE_W:0] diff;
  logic [CODE_W:0]      mag;
  logic                 unused_fine_lo;

  // Only the upper fine nibble is resolved by the SAR.
  assign unused_fine_lo = ^idacFine[3:0];

  assign is_eval   = (state_q == EVAL) || (state_q == LOCKED && lk_eval_q);
  assign acc_clear = !pwrup || (state_q == IDLE) || is_eval;

  bg_code_accum #(.LOG2N(LOG2N)) u_accum (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (acc_clear),
    .valid        (valid),
    .idac_coarse  (idacCoarse),
    .idac_fine_hi (idacFine[7:4]),
    .valid_edge   (valid_edge),
    .avg          (avg),
    .window_done  (window_done)
  );

  assign diff  = $signed({1'b0, avg}) - $signed({1'b0, prev_q});
  assign mag   = diff[CODE_W] ? $unsigned(-diff) : $unsigned(diff);
  assign agree = (mag <= TOL_C);

  always_comb begin
    // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
    agree_nxt = 4'd0;
    if (!first_q && agree) agree_nxt = (agree_q == LOCK_C) ? agree_q : agree_q + 4'd1;
  end

  // LOCKED keeps acquiring; lk_eval_q marks its evaluation cycle.
  always_comb begin
    state_d   = state_q;
    agree_d   = agree_q;
    lk_eval_d = 1'b0;
    if (!pwrup) begin
      state_d = IDLE;
      agree_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ACQ;
          agree_d = 4'd0;
        end
        ACQ:  if (window_done) state_d = EVAL;
        EVAL: begin
          agree_d = agree_nxt;
          state_d = (agree_nxt == LOCK_C) ? LOCKED : ACQ;
        end
        LOCKED: begin
          if (lk_eval_q) begin
            agree_d = agree_nxt;
            state_d = (agree_nxt == LOCK_C) ? LOCKED : ACQ;
          end else begin
            lk_eval_d = window_done;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wdog_d = wdog_q;
    if (!pwrup || state_q == IDLE || valid_edge) wdog_d = '0;
    else if (wdog_q != WDOG_MAX)                 wdog_d = wdog_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      first_q    <= 1'b1;
      lk_eval_q  <= 1'b0;
      agree_q    <= 4'd0;
      prev_q     <= '0;
      wdog_q     <= '0;
      trimCode   <= TRIM_CODE_RESET;
      trimUpdate <= 1'b0;
      locked     <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      state_q    <= state_d;
      lk_eval_q  <= lk_eval_d;
      agree_q    <= agree_d;
      wdog_q     <= wdog_d;
      trimUpdate <= pwrup && is_eval;
      locked     <= (state_d == LOCKED);
      if (!pwrup)                timeoutErr <= 1'b0;
      else if (wdog_d == WDOG_MAX) timeoutErr <= 1'b1;
      // trimCode deliberately survives power-down: the chip keeps its last good trim.
      if (!pwrup || state_q == IDLE) begin
        first_q <= 1'b1;
        prev_q  <= '0;
      end else if (is_eval) begin
        trimCode <= avg;
        prev_q   <= avg;
        first_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bg_trim_filter.sv
// Self-checking bench for bg_trim_filter: directed scenarios plus randomized
// trim results compared against a window-level reference model.
`timescale 1ns/1ps
module tb_bg_trim_filter;

  localparam int LOG2N     = 2;
  localparam int TOL       = 2;
  localparam int LOCK_CNT  = 3;
  localparam int TIMEOUT_W = 6;
  localparam int NWIN      = 1 << LOG2N;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pwrup = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  idac_coarse = 8'h00;
  logic [7:0]  idac_fine = 8'h00;
  logic [11:0] trim_code;
  logic        trim_update, locked, timeout_err;

  bg_trim_filter #(
    .LOG2N(LOG2N), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pwrup      (pwrup),
    .valid      (valid),
    .idacCoarse (idac_coarse),
    .idacFine   (idac_fine),
    .trimCode   (trim_code),
    .trimUpdate (trim_update),
    .locked     (locked),
    .timeoutErr (timeout_err)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: groups samples into windows of NWIN and applies the agreement rules.
  typedef struct {
    logic [11:0] code;
    logic        lck;
    int          upd_cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          win_sum, win_n, m_prev, m_agree;
  bit          m_first;
  logic [11:0] last_avg = 12'h800;

  task automatic model_reset();
    win_sum = 0;
    win_n   = 0;
    m_agree = 0;
    m_first = 1'b1;
    exp_q.delete();
  endtask

  task automatic model_sample(input int code, input int upd_cyc);
    int avg_i, d;
    exp_t e;
    win_sum += code;
    win_n++;
    if (win_n == NWIN) begin
      avg_i = win_sum / NWIN;
      d = avg_i - m_prev;
      if (d < 0) d = -d;
      if (m_first)       m_agree = 0;
      else if (d <= TOL) m_agree = (m_agree + 1 > LOCK_CNT) ? LOCK_CNT : m_agree + 1;
      else               m_agree = 0;
      m_first = 1'b0;
      m_prev  = avg_i;
      e.code = 12'(avg_i);
      e.lck = (m_agree == LOCK_CNT);
      e.upd_cyc = upd_cyc;
      exp_q.push_back(e);
      last_avg = 12'(avg_i);
      win_sum = 0;
      win_n   = 0;
    end
  endtask

  // One trim result: valid high for hi cycles, low for gap cycles; data scrambled after the edge.
  task automatic send(input logic [11:0] code, input int hi, input int gap);
    @(negedge clk);
    idac_coarse = code[11:4];
    idac_fine   = {code[3:0], 4'($urandom)};
    valid       = 1'b1;
    model_sample(int'(code), cyc + 3);
    for (int i = 0; i < hi; i++) begin
      @(negedge clk);
      {idac_coarse, idac_fine} = 16'($urandom);
    end
    valid = 1'b0;
    for (int i = 1; i < gap; i++) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset_n && trim_update) begin
      if (exp_q.size() == 0) begin
        check("upd_spurious", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("trim_code", trim_code, mon_e.code);
        check("locked_at_upd", locked, mon_e.lck);
        check("upd_cycle", cyc, mon_e.upd_cyc);
        check("timeout_clear", timeout_err, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [11:0] base, code;
    logic [11:0] win4 [4];

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_code", trim_code, 12'h800);
    check("rst_upd", trim_update, 0);
    check("rst_locked", locked, 0);
    check("rst_timeout", timeout_err, 0);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    pwrup = 1'b1;
    repeat (2) @(negedge clk);

    // Basic window average with truncation.
    send(12'h850, 1, 2);
    send(12'h852, 1, 2);
    send(12'h851, 1, 2);
    send(12'h853, 1, 2);
    drain();
    check("t2_code", trim_code, 12'h851);
    @(negedge clk);
    check("t2_upd_one_cycle", trim_update, 0);

    // Long valid pulses: one sample per pulse.
    for (int i = 0; i < 4; i++) send(12'($urandom), 3, 1 + $urandom_range(0, 2));
    drain();

    // Power-down clears history, keeps the trim code.
    @(negedge clk);
    pwrup = 1'b0;
    @(negedge clk);
    check("pd_locked", locked, 0);
    check("pd_upd", trim_update, 0);
    check("pd_code_kept", trim_code, last_avg);
    model_reset();
    pwrup = 1'b1;
    repeat (2) @(negedge clk);

    // Lock acquisition and loss.
    win4 = '{12'h851, 12'h852, 12'h850, 12'h852};
    for (int w = 0; w < 4; w++) begin
      for (int s = 0; s < 4; s++) send(win4[w], 1 + $urandom_range(0, 1), 1 + $urandom_range(0, 2));
      drain();
      if (w == 2) check("t4_not_yet_locked", locked, 0);
    end
    @(negedge clk);
    check("t4_locked", locked, 1);
    for (int s = 0; s < 4; s++) send(12'h860, 1, 2);
    drain();
    @(negedge clk);
    check("t4_unlocked", locked, 0);

    // Edge during the evaluation cycle opens the next window.
    for (int s = 0; s < 3; s++) send(12'h100, 1, 2);
    send(12'h100, 1, 1);
    for (int s = 0; s < 4; s++) send(12'h200, 1, 2);
    drain();
    check("t6_code", trim_code, 12'h200);

    // Code extremes: full-scale accumulation and a maximal jump.
    for (int s = 0; s < 4; s++) send(12'hFFF, 1, 1);
    for (int s = 0; s < 4; s++) send(12'h000, 1, 1);
    drain();
    check("ext_code", trim_code, 12'h000);

    // Randomized windows; drifting base lets the filter lock now and then.
    base = 12'h400;
    for (int w = 0; w < 36; w++) begin
      if (w % 6 == 0) base = 12'($urandom_range(16, 4000));
      for (int s = 0; s < 4; s++) begin
        code = (w % 6 == 5) ? 12'($urandom) : base + 12'($urandom_range(0, 4));
        send(code, 1 + $urandom_range(0, 3), 1 + $urandom_range(0, 4));
      end
    end
    drain();

    // Asynchronous reset in the middle of a window.
    send(12'h3A0, 1, 2);
    send(12'h3A0, 1, 2);
    #10;
    reset_n = 1'b0;
    #1;
    check("rst_mid_code", trim_code, 12'h800);
    check("rst_mid_upd", trim_update, 0);
    check("rst_mid_locked", locked, 0);
    check("rst_mid_timeout", timeout_err, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    send(12'h400, 1, 2);
    send(12'h401, 1, 2);
    send(12'h402, 1, 2);
    send(12'h403, 1, 2);
    drain();
    check("rst_fresh_avg", trim_code, 12'h401);

    // Watchdog timeout with no valid activity.
    @(negedge clk);
    pwrup = 1'b0;
    @(negedge clk);
    model_reset();
    pwrup = 1'b1;
    @(posedge clk);
    repeat (62) @(posedge clk);
    @(negedge clk);
    check("t5_before", timeout_err, 0);
    @(posedge clk);
    @(negedge clk);
    check("t5_set", timeout_err, 1);
    repeat (5) @(negedge clk);
    check("t5_sticky", timeout_err, 1);
    pwrup = 1'b0;
    @(negedge clk);
    check("t5_cleared", timeout_err, 0);
    check("t5_code_kept", trim_code, 12'h401);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
